// File: rtl/mpi_allreduce_seq.sv
// Host-side sequencer for the MPI allreduce engine: runs a batch of iterations,
// pulses the engine start bit per iteration and keeps cycle statistics.
module mpi_allreduce_seq #(
  parameter int unsigned START_HOLD = 4,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0][31:0] host_reg,
  output logic [7:0][31:0]  host_status,
  output logic [15:0][31:0] control_reg,
  input  logic [3:0][31:0]  status_reg,
  output logic [2:0]        state_dbg
);

  localparam logic [31:0] HOLD_LAST = 32'(START_HOLD - 1);
  localparam logic [31:0] GAP_MIN   = 32'(MIN_GAP);
  localparam logic [31:0] CYC_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t state;

  logic run_q, run_p, abort_q, abort_p;
  logic send_q, send_p, reduce_q, reduce_p;
  logic run_rise, abort_rise, send_rise, reduce_rise;
  logic send_hit, reduce_hit;

  logic [10:0][31:0] data_q;
  logic              start;
  logic [31:0]       n_q, t_q, gap_q;
  logic [31:0]       hold_cnt, gap_cnt, cyc, cyc_next;
  logic              send_seen, reduce_seen;
  logic              busy, done, tmo, aborted;
  logic [31:0]       iters_q, last_q, min_q, max_q, fail_q;
  logic [63:0]       total_q;

  logic unused_bits;
  assign unused_bits = ^{status_reg[3:2], status_reg[1][31:1], status_reg[0][31:1],
                         host_reg[15:14], host_reg[4][31:2]};

  // Edges are taken between the single input register and its history bit.
  assign run_rise    = run_q & ~run_p;
  assign abort_rise  = abort_q & ~abort_p;
  assign send_rise   = send_q & ~send_p;
  assign reduce_rise = reduce_q & ~reduce_p;
  assign send_hit    = send_seen | send_rise;
  assign reduce_hit  = reduce_seen | reduce_rise;
  assign cyc_next    = (cyc == CYC_MAX) ? cyc : cyc + 32'd1;
  assign state_dbg   = state;

  always_comb begin
    control_reg       = '0;
    control_reg[10:0] = data_q;
    control_reg[4]    = {31'd0, start};
  end

  always_comb begin
    host_status         = '0;
    host_status[0][3:0] = {aborted, tmo, done, busy};
    host_status[1]      = iters_q;
    host_status[2]      = last_q;
    host_status[3]      = total_q[31:0];
    host_status[4]      = total_q[63:32];
    host_status[5]      = min_q;
    host_status[6]      = max_q;
    host_status[7]      = fail_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      run_q       <= 1'b0;
      run_p       <= 1'b0;
      abort_q     <= 1'b0;
      abort_p     <= 1'b0;
      send_q      <= 1'b0;
      send_p      <= 1'b0;
      reduce_q    <= 1'b0;
      reduce_p    <= 1'b0;
      data_q      <= '0;
      start       <= 1'b0;
      n_q         <= '0;
      t_q         <= '0;
      gap_q       <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      cyc         <= '0;
      send_seen   <= 1'b0;
      reduce_seen <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tmo         <= 1'b0;
      aborted     <= 1'b0;
      iters_q     <= '0;
      last_q      <= '0;
      total_q     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      fail_q      <= '0;
    end else begin
      run_q    <= host_reg[4][0];
      run_p    <= run_q;
      abort_q  <= host_reg[4][1];
      abort_p  <= abort_q;
      send_q   <= status_reg[0][0];
      send_p   <= send_q;
      reduce_q <= status_reg[1][0];
      reduce_p <= reduce_q;

      if (abort_rise && state != S_IDLE && state != S_DONE) begin
        // Statistics are left as they stand so the host can inspect partial progress.
        start   <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
        state   <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (run_rise) state <= S_LOAD;
          end
          S_LOAD: begin
            data_q  <= host_reg[10:0];
            n_q     <= host_reg[11];
            t_q     <= host_reg[12];
            gap_q   <= (host_reg[13] > GAP_MIN) ? host_reg[13] : GAP_MIN;
            iters_q <= '0;
            last_q  <= '0;
            total_q <= '0;
            min_q   <= '1;
            max_q   <= '0;
            fail_q  <= '0;
            tmo     <= 1'b0;
            aborted <= 1'b0;
            done    <= (host_reg[11] == 32'd0);
            busy    <= (host_reg[11] != 32'd0);
            if (host_reg[11] == 32'd0) begin
              state <= S_DONE;
            end else begin
              start       <= 1'b1;
              hold_cnt    <= '0;
              cyc         <= '0;
              send_seen   <= 1'b0;
              reduce_seen <= 1'b0;
              state       <= S_START;
            end
          end
          S_START: begin
            cyc         <= cyc_next;
            send_seen   <= send_hit;
            reduce_seen <= reduce_hit;
            if (hold_cnt == HOLD_LAST) begin
              start <= 1'b0;
              state <= S_WAIT;
            end else begin
              hold_cnt <= hold_cnt + 32'd1;
            end
          end
          S_WAIT: begin
            cyc         <= cyc_next;
            send_seen   <= send_hit;
            reduce_seen <= reduce_hit;
            // Completion wins over a timeout landing on the same cycle.
            if (send_hit && reduce_hit) begin
              last_q  <= cyc;
              total_q <= total_q + {32'd0, cyc};
              min_q   <= (cyc < min_q) ? cyc : min_q;
              max_q   <= (cyc > max_q) ? cyc : max_q;
              iters_q <= iters_q + 32'd1;
              if (iters_q + 32'd1 == n_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end else if (t_q != 32'd0 && cyc == t_q) begin
              tmo    <= 1'b1;
              fail_q <= iters_q;
              busy   <= 1'b0;
              state  <= S_ERR;
            end
          end
          S_GAP: begin
            if (gap_cnt + 32'd1 >= gap_q) begin
              start       <= 1'b1;
              hold_cnt    <= '0;
              cyc         <= '0;
              send_seen   <= 1'b0;
              reduce_seen <= 1'b0;
              state       <= S_START;
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          S_ERR: begin
            if (!run_q) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpi_allreduce_seq.sv
// Bench for mpi_allreduce_seq: engine model reacting to start pulses, a batch-level
// reference model, and table, hand-written and random batches.
module tb_mpi_allreduce_seq;

  localparam int HOLD    = 4;
  localparam int MIN_GAP = 2;
  localparam int NEVER   = 0;
  localparam int MAXN    = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [15:0][31:0] host_reg = '0;
  logic [7:0][31:0]  host_status;
  logic [15:0][31:0] control_reg;
  logic [3:0][31:0]  status_reg = '0;
  logic [2:0]        state_dbg;

  always #5 clk = ~clk;

  mpi_allreduce_seq #(.START_HOLD(HOLD), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .rstn(rstn), .host_reg(host_reg), .host_status(host_status),
    .control_reg(control_reg), .status_reg(status_reg), .state_dbg(state_dbg)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int n; int t; int g; int sd; int rd; int miss;
  } vin_t;

  typedef struct {
    logic        done;
    logic        tmo;
    logic [31:0] iters, last, min, max, fidx;
    logic [63:0] total;
    logic [31:0] c[MAXN];
  } res_t;

  typedef struct {
    vin_t in;
    res_t exp;
  } vec_t;

  int          sd_tab[MAXN];
  int          rd_tab[MAXN];
  logic [31:0] exp_q[$];
  logic [31:0] data_w[11];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Batch outcome from the rules: an iteration lasts until one cycle after the later
  // done edge (never shorter than the start hold); a timeout hits while waiting.
  function automatic res_t model(input int n, input int t);
    res_t        r;
    logic [31:0] c;
    int          d;
    r.done = 1'b0; r.tmo = 1'b0; r.iters = 0; r.last = 0;
    r.min = '1; r.max = 0; r.fidx = 0; r.total = 0;
    for (int i = 0; i < MAXN; i++) r.c[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (rd_tab[i] == NEVER) c = '1;
      else begin
        d = (sd_tab[i] > rd_tab[i]) ? sd_tab[i] : rd_tab[i];
        c = (d + 1 > HOLD) ? d + 1 : HOLD;
      end
      if (t != 0 && t >= HOLD && t < c) begin
        r.tmo = 1'b1;
        r.fidx = i;
        return r;
      end
      r.c[i] = c;
      r.last = c;
      r.total += {32'd0, c};
      if (c < r.min) r.min = c;
      if (c > r.max) r.max = c;
      r.iters++;
    end
    r.done = 1'b1;
    return r;
  endfunction

  // Engine model and start-pulse monitor.
  int   batch_id = 0, seen_batch = 0, pulses = 0, rise_cyc = 0, first_rise = 0;
  int   hi_len = 0, low_len = 0, mon_gap = MIN_GAP;
  logic prev_start = 1'b0, sd_lvl = 1'b0, rd_lvl = 1'b0;

  initial begin
    logic [31:0] noise;
    int          idx;
    forever begin
      @(negedge clk);
      if (batch_id != seen_batch) begin
        seen_batch = batch_id;
        pulses = 0;
      end
      if (!rstn) begin
        prev_start = 1'b0; hi_len = 0; low_len = 0; sd_lvl = 1'b0; rd_lvl = 1'b0;
      end else begin
        if (control_reg[4][0] && !prev_start) begin
          if (pulses > 0) check("start_gap", low_len >= mon_gap, 1);
          pulses++;
          if (pulses == 1) first_rise = cycle;
          rise_cyc = cycle;
          sd_lvl = 1'b0;
          rd_lvl = 1'b0;
          hi_len = 0;
        end
        if (!control_reg[4][0] && prev_start) begin
          check("start_width", hi_len, HOLD);
          low_len = 0;
        end
        if (control_reg[4][0]) hi_len++;
        else low_len++;
        if (pulses > 0 && pulses <= MAXN) begin
          idx = pulses - 1;
          if (cycle - rise_cyc == sd_tab[idx]) sd_lvl = 1'b1;
          if (rd_tab[idx] != NEVER && cycle - rise_cyc == rd_tab[idx]) rd_lvl = 1'b1;
        end
        prev_start = control_reg[4][0];
      end
      noise = $urandom();
      status_reg[0] = {noise[31:1], sd_lvl};
      status_reg[1] = {noise[30:0], rd_lvl};
      status_reg[2] = noise;
    end
  end

  // Every wait goes through tick, which also scoreboards each completed iteration.
  logic [31:0] sb_prev = 0;
  task automatic tick();
    @(negedge clk);
    if (rstn && host_status[1] == sb_prev + 32'd1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: got iteration %0d, expected none", host_status[1]);
      end else begin
        check("iter_cycles", host_status[2], exp_q.pop_front());
      end
    end
    sb_prev = host_status[1];
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (k < budget && !(host_status[0][0] == 1'b0 && (|host_status[0][3:1]))) begin
      tick();
      k++;
    end
    check("end_reached", k < budget, 1);
  endtask

  task automatic wait_pulses(input int p, input int budget);
    int k = 0;
    while (k < budget && pulses < p) begin
      tick();
      k++;
    end
    check("pulse_seen", pulses >= p, 1);
  endtask

  task automatic set_tabs(input vin_t v);
    for (int i = 0; i < MAXN; i++) begin
      sd_tab[i] = v.sd;
      rd_tab[i] = (i == v.miss) ? NEVER : v.rd;
    end
  endtask

  task automatic start_batch(input int n, input int t, input int g, output int t0);
    batch_id++;
    mon_gap = (g > MIN_GAP) ? g : MIN_GAP;
    for (int i = 0; i < 11; i++) begin
      if (i != 4) begin
        data_w[i] = $urandom();
        host_reg[i] = data_w[i];
      end
    end
    host_reg[11] = n;
    host_reg[12] = t;
    host_reg[13] = g;
    host_reg[4] = 32'h1;
    t0 = cycle;
    repeat (3) tick();
    // Host words changed after the load must not reach the engine.
    for (int i = 0; i < 11; i++) if (i != 4) host_reg[i] = $urandom();
  endtask

  task automatic push_exp(input res_t r);
    for (int i = 0; i < int'(r.iters); i++) exp_q.push_back(r.c[i]);
  endtask

  task automatic finish_batch(input vec_t v, input int t0);
    wait_end(4000);
    check("done", host_status[0][1], v.exp.done);
    check("timeout", host_status[0][2], v.exp.tmo);
    check("aborted", host_status[0][3], 0);
    check("busy", host_status[0][0], 0);
    check("iters", host_status[1], v.exp.iters);
    check("last_cycles", host_status[2], v.exp.last);
    check("total_cycles", {host_status[4], host_status[3]}, v.exp.total);
    check("min_cycles", host_status[5], v.exp.min);
    check("max_cycles", host_status[6], v.exp.max);
    check("fail_index", host_status[7], v.exp.fidx);
    for (int i = 0; i < 11; i++) if (i != 4) check("ctrl_word", control_reg[i], data_w[i]);
    check("ctrl_unused_zero", |control_reg[15:11], 0);
    if (v.in.n > 0) check("start_latency", first_rise, t0 + 3);
    check("pulses", pulses, v.exp.iters + v.exp.tmo);
    check("sb_left", exp_q.size(), 0);
    exp_q.delete();
    host_reg[4] = 32'h0;
    repeat (4) tick();
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    set_tabs(v.in);
    push_exp(v.exp);
    start_batch(v.in.n, v.in.t, v.in.g, t0);
    if (v.in.n == 0) check("n0_done_latency", host_status[0][1], 1);
    finish_batch(v, t0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   t0;

    tbl[0].in = '{n:3, t:0,   g:0, sd:100, rd:100, miss:-1};
    tbl[1].in = '{n:1, t:0,   g:0, sd:50,  rd:80,  miss:-1};
    tbl[2].in = '{n:5, t:200, g:3, sd:40,  rd:60,  miss:2};
    tbl[3].in = '{n:2, t:0,   g:7, sd:12,  rd:9,   miss:-1};
    tbl[4].in = '{n:0, t:0,   g:0, sd:10,  rd:10,  miss:-1};
    tbl[5].in = '{n:2, t:30,  g:1, sd:20,  rd:29,  miss:-1};
    tbl[6].in = '{n:1, t:29,  g:1, sd:20,  rd:29,  miss:-1};
    for (int k = 0; k < 7; k++) begin
      set_tabs(tbl[k].in);
      tbl[k].exp = model(tbl[k].in.n, tbl[k].in.t);
    end

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_status_zero", |host_status, 0);
    check("rst_ctrl_zero", |control_reg, 0);
    rstn = 1'b1;
    repeat (2) tick();
    check("post_rst_status_zero", |host_status, 0);
    check("post_rst_start_low", control_reg[4][0], 0);

    for (int k = 0; k < 7; k++) run_vec(tbl[k]);

    // An early send_done level must not close the iteration on its own.
    v.in = '{n:1, t:0, g:0, sd:50, rd:80, miss:-1};
    set_tabs(v.in);
    v.exp = model(1, 0);
    push_exp(v.exp);
    start_batch(1, 0, 0, t0);
    wait_pulses(1, 20);
    while (cycle < rise_cyc + 70) tick();
    check("early_send_no_close", host_status[1], 0);
    check("early_send_busy", host_status[0][0], 1);
    finish_batch(v, t0);

    // Abort while waiting on the second iteration.
    v.in = '{n:3, t:0, g:0, sd:30, rd:30, miss:-1};
    set_tabs(v.in);
    exp_q.push_back(32'd31);
    start_batch(3, 0, 0, t0);
    wait_pulses(2, 200);
    repeat (HOLD + 4) tick();
    host_reg[4] = 32'h3;
    repeat (2) tick();
    check("abort_start_low", control_reg[4][0], 0);
    check("abort_flag", host_status[0][3], 1);
    check("abort_busy", host_status[0][0], 0);
    check("abort_done", host_status[0][1], 0);
    check("abort_iters", host_status[1], 1);
    check("abort_last", host_status[2], 31);
    check("abort_sb_left", exp_q.size(), 0);
    exp_q.delete();
    host_reg[4] = 32'h0;
    repeat (4) tick();

    // Asynchronous reset in the middle of a start pulse, then a fresh batch.
    v.in = '{n:2, t:0, g:0, sd:20, rd:20, miss:-1};
    set_tabs(v.in);
    start_batch(2, 0, 0, t0);
    tick();
    check("pre_rst_start_high", control_reg[4][0], 1);
    #2 rstn = 1'b0;
    host_reg[4] = 32'h0;
    #1;
    check("midrst_start_low", control_reg[4][0], 0);
    check("midrst_status_zero", |host_status, 0);
    check("midrst_ctrl_zero", |control_reg, 0);
    tick();
    #2 rstn = 1'b1;
    tick();
    exp_q.delete();
    repeat (2) tick();
    v.in = '{n:2, t:0, g:2, sd:15, rd:25, miss:-1};
    set_tabs(v.in);
    v.exp = model(2, 0);
    run_vec(v);

    // Random batches with per-iteration engine delays.
    for (int k = 0; k < 6; k++) begin
      v.in.n = $urandom_range(1, 6);
      v.in.g = $urandom_range(0, 5);
      v.in.t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(40, 150));
      v.in.sd = 0;
      v.in.rd = 0;
      v.in.miss = -1;
      for (int i = 0; i < MAXN; i++) begin
        sd_tab[i] = $urandom_range(6, 90);
        rd_tab[i] = $urandom_range(6, 90);
      end
      if (v.in.t != 0 && $urandom_range(0, 3) == 0) begin
        v.in.miss = $urandom_range(0, v.in.n - 1);
        rd_tab[v.in.miss] = NEVER;
      end
      v.exp = model(v.in.n, v.in.t);
      push_exp(v.exp);
      start_batch(v.in.n, v.in.t, v.in.g, t0);
      finish_batch(v, t0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpi_allreduce_seq.md
# mpi_allreduce_seq

Host-side sequencer directly upstream of the MPI allreduce engine. It owns the engine's 16-word `control_reg` bus and consumes its 4-word `status_reg`. It runs a batch of back-to-back allreduce iterations from one host command, and generates a clean start pulse for each. It records per-iteration and aggregate cycle counts and flags timeouts for the host.

## Interface
Parameters:
- `START_HOLD`, default 4: cycles `control_reg[4][0]` is held high per iteration (≥2).
- `MIN_GAP`, default 2: minimum low cycles on the start bit between iterations.

Ports:
- `clk`  in  1  user clock; sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `host_reg`  in  [15:0][31:0]  host configuration:
  - words 0–3, 5–10: forwarded to the engine.
  - [4][0] run; [4][1] abort.
  - [11] iteration count.
  - [12] timeout cycles (0 = disabled).
  - [13] inter-iteration gap.
- `host_status`  out  [7:0][31:0]:
  - [0]: bit0 busy, bit1 done, bit2 timeout, bit3 aborted.
  - [1] iterations completed; [2] last iteration cycles.
  - [3]/[4] total cycles low/high; [5] min; [6] max.
  - [7] index of the failing iteration.
- `control_reg`  out  [15:0][31:0]  to the engine.
- `status_reg`  in  [3:0][31:0]  from the engine. [0][0] send_done, [1][0] reduce_done; other bits ignored.

## Operation
- Inputs `host_reg[4][1:0]`, `status_reg[0][0]` and `status_reg[1][0]` are registered once. Edges are detected against that registered copy.
- FSM states: IDLE, LOAD, START, WAIT, GAP, DONE, ERR.
- IDLE: on a rising edge of run, go to LOAD. Other `host_reg` changes are ignored.
- LOAD:
  - Latch words 0–3, 5–10 into `control_reg` (the same word indices); they are held stable until the next LOAD.
  - Latch iteration count N, timeout T and gap G. The effective gap is max(G, MIN_GAP).
  - Clear `host_status` words 1–7, but set [5] to 0xFFFF_FFFF.
  - Set busy and clear done/timeout/aborted.
  - If N == 0, go to DONE; otherwise go to START.
- START:
  - Drive `control_reg[4][0]` = 1 for START_HOLD cycles, then 0 and go to WAIT.
  - On entry, clear the send_seen and reduce_seen flags and zero the iteration cycle counter.
- WAIT:
  - send_seen is set on a rising edge of the registered send_done; reduce_seen likewise on reduce_done. Rising edges occurring during START also count.
  - When both flags are set (including both in the same cycle), close the iteration:
    - [2] = cyc.
    - {[4],[3]} += cyc.
    - [5] = min([5], cyc); [6] = max([6], cyc).
    - [1] += 1.
  - Then go to GAP, or to DONE if [1] reaches N.
- Iteration cycle counter cyc: 32-bit, counts every cycle from START entry, saturates at 0xFFFF_FFFF. The 64-bit total wraps naturally.
- Timeout: if T ≠ 0 and cyc == T while in WAIT, set timeout, set [7] = [1] (0-based index), and go to ERR.
- GAP: count the effective gap cycles with start low, then go to START.
- DONE: clear busy, set done, go to IDLE.
- ERR: clear busy. Stay in ERR until run falls, then go to IDLE.
- Abort (registered rising edge of [4][1]) in any state other than IDLE/DONE:
  - Force start low and clear busy.
  - Set aborted and go to IDLE next cycle.
  - Statistics keep their partial values.
- A run edge while busy is ignored.

## Timing
- Reset: all `control_reg` words 0, all `host_status` words 0, FSM in IDLE.
- The run edge appears at the block input in cycle t; the registered copy is valid in t+1.
  - LOAD in t+2.
  - `control_reg` data valid, and start = 1, in t+3.
  - Start is high for cycles t+3 … t+3+START_HOLD−1.
- Between iterations the start bit is low for at least START_HOLD-to-WAIT time plus the effective gap, and never less than MIN_GAP cycles.
- A done edge at the input in cycle u is recorded in u+1. Statistics update in the cycle after both flags are set.
- `host_status` words are registered outputs.
- Reset asserted mid-batch returns everything to its reset values immediately (asynchronously).

## Test plan
- N=3, gap=0 (effective 2), engine model asserts both done levels 100 cycles after start → done=1, [1]=3, [5]=[6]=[2]; start high exactly 4 cycles each; ≥2 low cycles between pulses.
- send_done at +50, reduce_done at +80 in the same iteration → iteration closes at +80; [2] ≈ 81; an early send_done level held high does not close the iteration alone.
- N=5, T=200, engine never raises reduce_done on iteration 2 → timeout=1, [1]=2, [7]=2, busy=0; run toggled low then high restarts cleanly.
- Abort asserted during WAIT of iteration 1 → start low next cycle, aborted=1, busy=0, [1]=1.
- N=0 → done=1 within 3 cycles of the run edge, no start pulse, [1]=0.
- rstn pulsed low during START → `control_reg[4][0]` drops immediately; all status 0; a fresh run edge after reset completes normally.
